// File: rtl/char_writer.sv
// ============================================================================
// Module   : char_writer
// Brief    : Terminal-style character writer: places bytes into text RAM,
//            tracks the cursor, and drives scroll and clear sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module char_writer #(
  parameter int COL_BITS = 7,
  parameter int ROW_BITS = 5,
  parameter int COLS     = 80,
  parameter int ROWS     = 30
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [COL_BITS-1:0] new_x,
  output logic [ROW_BITS-1:0] new_y,
  output logic                cursor_wen,
  output logic [COL_BITS-1:0] vram_x,
  output logic [ROW_BITS-1:0] vram_y,
  output logic [7:0]          vram_data,
  output logic                vram_wen,
  output logic                scroll_req,
  input  logic                scroll_ack
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_SCROLL    = 2'd1,
    S_CLEAR_ROW = 2'd2,
    S_CLEAR_ALL = 2'd3
  } state_t;

  localparam logic [COL_BITS-1:0] c_LAST_COL = COL_BITS'(COLS - 1);
  localparam logic [ROW_BITS-1:0] c_LAST_ROW = ROW_BITS'(ROWS - 1);
  localparam logic [7:0]          c_SPACE    = 8'h20;

  state_t              r_state, w_state;
  logic [COL_BITS-1:0] r_x, w_x, r_cx, w_cx, r_vram_x, w_vram_x;
  logic [ROW_BITS-1:0] r_y, w_y, r_cy, w_cy, r_vram_y, w_vram_y;
  logic [7:0]          r_vram_data, w_vram_data;
  logic                r_cursor_wen, w_cursor_wen;
  logic                r_vram_wen, w_vram_wen;
  logic                r_scroll_req, w_scroll_req;
  logic                r_in_ready, w_in_ready;

  always_comb begin
    w_state      = r_state;
    w_x          = r_x;
    w_y          = r_y;
    w_cx         = r_cx;
    w_cy         = r_cy;
    w_cursor_wen = 1'b0;
    w_vram_wen   = 1'b0;
    w_vram_x     = r_vram_x;
    w_vram_y     = r_vram_y;
    w_vram_data  = c_SPACE;
    w_scroll_req = r_scroll_req;

    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          if (in_data >= 8'h20 && in_data <= 8'h7E) begin
            w_vram_wen   = 1'b1;
            w_vram_x     = r_x;
            w_vram_y     = r_y;
            w_vram_data  = in_data;
            w_cursor_wen = 1'b1;
            if (r_x == c_LAST_COL) begin
              w_x = '0;
              // Wrapping off the bottom row keeps the cursor on the last row
              // and scrolls the screen underneath it.
              if (r_y == c_LAST_ROW) begin
                w_state      = S_SCROLL;
                w_scroll_req = 1'b1;
              end else begin
                w_y = r_y + 1'b1;
              end
            end else begin
              w_x = r_x + 1'b1;
            end
          end else begin
            case (in_data)
              8'h0D: begin
                w_cursor_wen = 1'b1;
                w_x          = '0;
              end
              8'h0A: begin
                w_cursor_wen = 1'b1;
                if (r_y == c_LAST_ROW) begin
                  w_state      = S_SCROLL;
                  w_scroll_req = 1'b1;
                end else begin
                  w_y = r_y + 1'b1;
                end
              end
              8'h08: begin
                w_cursor_wen = 1'b1;
                if (r_x != '0) w_x = r_x - 1'b1;
              end
              8'h0C: begin
                w_state = S_CLEAR_ALL;
                w_cx    = '0;
                w_cy    = '0;
              end
              default: ;
            endcase
          end
        end
      end

      S_SCROLL: begin
        if (r_scroll_req && scroll_ack) begin
          w_scroll_req = 1'b0;
          w_state      = S_CLEAR_ROW;
          w_cx         = '0;
        end
      end

      S_CLEAR_ROW: begin
        w_vram_wen = 1'b1;
        w_vram_x   = r_cx;
        w_vram_y   = c_LAST_ROW;
        if (r_cx == c_LAST_COL) w_state = S_IDLE;
        else                    w_cx    = r_cx + 1'b1;
      end

      S_CLEAR_ALL: begin
        w_vram_wen = 1'b1;
        w_vram_x   = r_cx;
        w_vram_y   = r_cy;
        if (r_cx == c_LAST_COL) begin
          w_cx = '0;
          if (r_cy == c_LAST_ROW) begin
            w_state      = S_IDLE;
            w_x          = '0;
            w_y          = '0;
            w_cursor_wen = 1'b1;
          end else begin
            w_cy = r_cy + 1'b1;
          end
        end else begin
          w_cx = r_cx + 1'b1;
        end
      end

      default: w_state = S_IDLE;
    endcase

    w_in_ready = (w_state == S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_x          <= '0;
      r_y          <= '0;
      r_cx         <= '0;
      r_cy         <= '0;
      r_cursor_wen <= 1'b0;
      r_vram_wen   <= 1'b0;
      r_vram_x     <= '0;
      r_vram_y     <= '0;
      r_vram_data  <= c_SPACE;
      r_scroll_req <= 1'b0;
      r_in_ready   <= 1'b1;
    end else begin
      r_state      <= w_state;
      r_x          <= w_x;
      r_y          <= w_y;
      r_cx         <= w_cx;
      r_cy         <= w_cy;
      r_cursor_wen <= w_cursor_wen;
      r_vram_wen   <= w_vram_wen;
      r_vram_x     <= w_vram_x;
      r_vram_y     <= w_vram_y;
      r_vram_data  <= w_vram_data;
      r_scroll_req <= w_scroll_req;
      r_in_ready   <= w_in_ready;
    end
  end

  assign in_ready   = r_in_ready;
  assign new_x      = r_x;
  assign new_y      = r_y;
  assign cursor_wen = r_cursor_wen;
  assign vram_x     = r_vram_x;
  assign vram_y     = r_vram_y;
  assign vram_data  = r_vram_data;
  assign vram_wen   = r_vram_wen;
  assign scroll_req = r_scroll_req;

endmodule

`default_nettype wire

// File: tb/tb_char_writer.sv
// ============================================================================
// Module   : tb_char_writer
// Brief    : Directed, table-driven bench for char_writer (80x30 geometry).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_char_writer;

  logic       clk;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] new_x;
  logic [4:0] new_y;
  logic       cursor_wen;
  logic [6:0] vram_x;
  logic [4:0] vram_y;
  logic [7:0] vram_data;
  logic       vram_wen;
  logic       scroll_req;
  logic       scroll_ack;

  char_writer #(.COL_BITS(7), .ROW_BITS(5), .COLS(80), .ROWS(30)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .new_x(new_x), .new_y(new_y), .cursor_wen(cursor_wen),
    .vram_x(vram_x), .vram_y(vram_y), .vram_data(vram_data), .vram_wen(vram_wen),
    .scroll_req(scroll_req), .scroll_ack(scroll_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Present one byte at a negedge; returns at the negedge after acceptance.
  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       vwen;
    logic [7:0] vx;
    logic [7:0] vy;
    logic       cwen;
    logic [7:0] nx;
    logic [7:0] ny;
  } vec_t;

  vec_t vecs[14];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int cnt, errs, guard, cw, ex, ey;

    vecs[0]  = '{8'h41, 1'b1, 8'd0, 8'd0, 1'b1, 8'd1, 8'd0};  // 'A'
    vecs[1]  = '{8'h42, 1'b1, 8'd1, 8'd0, 1'b1, 8'd2, 8'd0};  // 'B'
    vecs[2]  = '{8'h0D, 1'b0, 8'd0, 8'd0, 1'b1, 8'd0, 8'd0};  // CR
    vecs[3]  = '{8'h0A, 1'b0, 8'd0, 8'd0, 1'b1, 8'd0, 8'd1};  // LF
    vecs[4]  = '{8'h0A, 1'b0, 8'd0, 8'd0, 1'b1, 8'd0, 8'd2};  // LF
    vecs[5]  = '{8'h08, 1'b0, 8'd0, 8'd0, 1'b1, 8'd0, 8'd2};  // BS at x=0
    vecs[6]  = '{8'h43, 1'b1, 8'd0, 8'd2, 1'b1, 8'd1, 8'd2};  // 'C'
    vecs[7]  = '{8'h08, 1'b0, 8'd0, 8'd0, 1'b1, 8'd0, 8'd2};  // BS
    vecs[8]  = '{8'h00, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd2};  // ignored
    vecs[9]  = '{8'h7F, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd2};  // ignored
    vecs[10] = '{8'h1F, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd2};  // ignored
    vecs[11] = '{8'h7E, 1'b1, 8'd0, 8'd2, 1'b1, 8'd1, 8'd2};  // '~'
    vecs[12] = '{8'h20, 1'b1, 8'd1, 8'd2, 1'b1, 8'd2, 8'd2};  // ' '
    vecs[13] = '{8'h0D, 1'b0, 8'd0, 8'd0, 1'b1, 8'd0, 8'd2};  // CR

    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; scroll_ack = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_cursor_wen", cursor_wen, 0);
    check("rst_vram_wen", vram_wen, 0);
    check("rst_vram_data", vram_data, 8'h20);
    check("rst_vram_xy", {vram_x, vram_y}, 0);
    check("rst_new_xy", {new_x, new_y}, 0);
    check("rst_scroll_req", scroll_req, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Table of single-byte transactions from the reset position.
    for (int i = 0; i < 14; i++) begin
      send(vecs[i].data);
      check($sformatf("v%0d_vram_wen", i), vram_wen, vecs[i].vwen);
      if (vecs[i].vwen) begin
        check($sformatf("v%0d_vram_x", i), vram_x, vecs[i].vx);
        check($sformatf("v%0d_vram_y", i), vram_y, vecs[i].vy);
        check($sformatf("v%0d_vram_data", i), vram_data, vecs[i].data);
      end else begin
        check($sformatf("v%0d_vram_data_idle", i), vram_data, 8'h20);
      end
      check($sformatf("v%0d_cursor_wen", i), cursor_wen, vecs[i].cwen);
      check($sformatf("v%0d_new_x", i), new_x, vecs[i].nx);
      check($sformatf("v%0d_new_y", i), new_y, vecs[i].ny);
      check($sformatf("v%0d_in_ready", i), in_ready, 1);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("v%0d_pulse_end", i), {vram_wen, cursor_wen}, 0);
    end

    // Wrap at the last column of a non-final row.
    repeat (3) send(8'h0A);
    repeat (79) send(8'h61);
    check("pre_wrap_xy", {new_x, new_y}, {7'd79, 5'd5});
    send(8'h5A);
    check("wrap_vram_wen", vram_wen, 1);
    check("wrap_vram_xy", {vram_x, vram_y}, {7'd79, 5'd5});
    check("wrap_vram_data", vram_data, 8'h5A);
    check("wrap_new_xy", {new_x, new_y}, {7'd0, 5'd6});
    check("wrap_no_scroll", scroll_req, 0);
    @(posedge clk); @(negedge clk);
    check("wrap_no_scroll_later", {scroll_req, in_ready}, 2'b01);

    // LF on the last row: scroll handshake then bottom-row clear.
    repeat (23) send(8'h0A);
    repeat (10) send(8'h62);
    check("pre_scroll_xy", {new_x, new_y}, {7'd10, 5'd29});
    send(8'h0A);
    check("lf_last_cursor_wen", cursor_wen, 1);
    check("lf_last_new_xy", {new_x, new_y}, {7'd10, 5'd29});
    errs = 0;
    for (int i = 0; i < 6; i++) begin
      if (scroll_req !== 1'b1 || in_ready !== 1'b0 || vram_wen !== 1'b0) errs++;
      if (i == 5) scroll_ack = 1'b1;
      @(posedge clk); @(negedge clk);
      scroll_ack = 1'b0;
    end
    check("scroll_req_6_cycles", errs, 0);
    check("scroll_req_dropped", scroll_req, 0);
    cnt = 0; errs = 0; guard = 0;
    while (cnt < 80 && guard < 300) begin
      if (vram_wen) begin
        if (vram_x !== cnt[6:0] || vram_y !== 5'd29 || vram_data !== 8'h20) errs++;
        cnt++;
      end
      if (cursor_wen || scroll_req) errs++;
      guard++;
      @(posedge clk); @(negedge clk);
    end
    check("clear_row_count", cnt, 80);
    check("clear_row_order", errs, 0);
    check("clear_row_cursor", {new_x, new_y}, {7'd10, 5'd29});
    check("clear_row_done", {vram_wen, in_ready}, 2'b01);

    // Mid-run reset, then BS and CR at (0,3).
    reset = 1'b0;
    #1;
    check("rst2_new_xy", {new_x, new_y}, 0);
    check("rst2_vram_data", vram_data, 8'h20);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    repeat (3) send(8'h0A);
    send(8'h08);
    check("bs_x0", {cursor_wen, vram_wen, new_x, new_y}, {1'b1, 1'b0, 7'd0, 5'd3});
    send(8'h0D);
    check("cr_x0", {cursor_wen, vram_wen, new_x, new_y}, {1'b1, 1'b0, 7'd0, 5'd3});

    // Full clear with a competing byte held valid throughout.
    send(8'h0C);
    in_valid = 1'b1; in_data = 8'h51;
    cnt = 0; errs = 0; guard = 0; cw = 0;
    while (cnt < 2400 && guard < 3000) begin
      if (in_ready && !(vram_wen && cnt == 2399)) errs++;
      if (cursor_wen) begin
        cw++;
        if (new_x !== 7'd0 || new_y !== 5'd0 || cnt != 2399) errs++;
      end
      if (vram_wen) begin
        ex = cnt % 80; ey = cnt / 80;
        if (vram_x !== ex[6:0] || vram_y !== ey[4:0] || vram_data !== 8'h20) errs++;
        cnt++;
        if (cnt == 2400) in_valid = 1'b0;
      end
      guard++;
      if (cnt < 2400) begin
        @(posedge clk); @(negedge clk);
      end
    end
    in_valid = 1'b0;
    check("ff_write_count", cnt, 2400);
    check("ff_order_ready", errs, 0);
    check("ff_cursor_wen_once", cw, 1);
    check("ff_cursor", {new_x, new_y}, 0);
    @(posedge clk); @(negedge clk);
    check("ff_done", {vram_wen, cursor_wen, in_ready}, 3'b001);

    // Reset in the middle of a full clear.
    send(8'h41);
    check("pre_ff2_xy", {new_x, new_y}, {7'd1, 5'd0});
    send(8'h0C);
    repeat (100) @(negedge clk);
    check("ff2_running", {vram_wen, in_ready}, 2'b10);
    #2 reset = 1'b0;
    in_valid = 1'b1; in_data = 8'h58;
    #1;
    check("ff2_rst_vram_wen", vram_wen, 0);
    check("ff2_rst_cursor", {new_x, new_y}, 0);
    check("ff2_rst_misc", {cursor_wen, scroll_req, vram_x, vram_y, vram_data},
          {1'b0, 1'b0, 7'd0, 5'd0, 8'h20});
    errs = 0;
    repeat (3) begin
      @(negedge clk);
      if (vram_wen || cursor_wen) errs++;
    end
    reset = 1'b1; in_valid = 1'b0;
    #1;
    check("ff2_ready_after_rst", in_ready, 1);
    repeat (5) begin
      @(negedge clk);
      if (vram_wen || cursor_wen) errs++;
    end
    check("ff2_abandoned", errs, 0);
    send(8'h4B);
    check("post_rst_write", {vram_wen, vram_x, vram_y, vram_data}, {1'b1, 7'd0, 5'd0, 8'h4B});
    check("post_rst_cursor", {cursor_wen, new_x, new_y}, {1'b1, 7'd1, 5'd0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
